writeback_unit: RTL and testbench
=================================

// Module: writeback_unit
// PURPOSE
//  Final pipeline stage: produces the register-file write port (Rw, RegWr, busW) consumed by decode.
//  Accepts one retiring instruction per handshake and selects the write data: ALU result, load data, PC+4 or immediate.
//  Waits for multi-cycle load responses and performs byte/half extraction with sign or zero extension.
//  Keeps a retire counter for debug.
// PARAMETERS
//  LOAD_TIMEOUT  16  max cycles in LOAD_WAIT without mem_rvalid before abort (>=1)
//  RETIRE_W      32  width of retire_cnt
// PORTS
//  clk         input   1   clock, rising edge
//  rst         input   1   synchronous active-low reset
//  in_valid    input   1   upstream instruction valid
//  in_ready    output  1   unit can accept (high only in IDLE)
//  in_rd       input   5   destination register
//  in_reg_wr   input   1   instruction writes rd
//  in_wb_sel   input   2   00 ALU, 01 LOAD, 10 PC+4, 11 IMM
//  in_funct3   input   3   load width/sign (RV32I encoding)
//  in_addr_lo  input   2   load byte offset (address[1:0])
//  in_alu      input   32  ALU result
//  in_pc       input   32  instruction PC
//  in_imm      input   32  immediate (LUI)
//  mem_rvalid  input   1   load data valid
//  mem_rdata   input   32  load data word (little-endian)
//  Rw          output  5   regfile write address
//  RegWr       output  1   regfile write enable, one-cycle pulse
//  busW        output  32  regfile write data
//  wb_err      output  1   one-cycle pulse: bad funct3, misaligned load, or timeout
//  retire_cnt  output  RETIRE_W  number of retired (accepted and completed) instructions
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, Rw=0, RegWr=0, busW=0, wb_err=0, retire_cnt=0, timeout counter=0.
//  - Reset has priority over all other inputs and aborts any pending load.
//  All outputs are registered. Accept = in_valid & in_ready.
//  FSM states: IDLE, LOAD_WAIT.
//  - IDLE, accept, wb_sel!=01:
//    - Next cycle: RegWr = in_reg_wr & (in_rd!=0), Rw=in_rd.
//    - busW = ALU / in_pc+32'd4 (wraps mod 2^32) / IMM.
//    - retire_cnt++. Stays in IDLE, so back-to-back accepts are possible every cycle.
//  - IDLE, accept, wb_sel==01:
//    - Latch rd, reg_wr, funct3, addr_lo; clear the timeout counter; go to LOAD_WAIT; in_ready=0.
//    - If funct3 is not in {000,001,010,100,101}, or LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0:
//      stay in IDLE instead, pulse wb_err next cycle, no write, retire_cnt++.
//  - LOAD_WAIT with mem_rvalid=1:
//    - Next cycle: RegWr = reg_wr & (rd!=0), busW = extracted data. Go to IDLE; retire_cnt++.
//  - LOAD_WAIT with mem_rvalid=0: counter++.
//    - When the counter reaches LOAD_TIMEOUT: pulse wb_err, no write, go to IDLE, retire_cnt++.
//    - mem_rvalid on the same cycle the counter would expire wins (normal write, no error).
//  - mem_rvalid in IDLE is ignored. rvalid is not sampled in the accept cycle (earliest load latency = 1).
//  Load extraction:
//  - LB/LBU: byte addr_lo, sign/zero extended.
//  - LH/LHU: half addr_lo[1], sign/zero extended.
//  - LW: full word.
//  rd==0: never asserts RegWr; the instruction still retires.
//  When RegWr=0: Rw/busW hold their last values. retire_cnt wraps at 2^RETIRE_W.
// TESTING
//  1. ALU, rd=5, in_alu=0xDEADBEEF accepted cycle N -> cycle N+1: RegWr=1, Rw=5, busW=0xDEADBEEF, retire_cnt=1.
//  2. LB, addr_lo=3, rdata=0x80FF_0000, rvalid 3 cycles after accept -> busW=0xFFFFFF80, RegWr pulse once.
//     Same case with LBU -> busW=0x00000080.
//  3. LW, no rvalid for LOAD_TIMEOUT=16 cycles -> wb_err pulse, RegWr never asserted, in_ready returns high.
//     Repeat with rvalid on the 16th cycle -> normal write, no wb_err.
//  4. PC+4 with in_pc=0xFFFFFFFC, rd=1 -> busW=0x00000000.
//     IMM with rd=0 -> RegWr stays 0, retire_cnt still increments.
//  5. LH with addr_lo=1 -> wb_err pulse, no LOAD_WAIT entry.
//     Four ALU ops back-to-back -> four consecutive RegWr pulses.
//  6. rst=0 asserted while in LOAD_WAIT -> next cycle all outputs 0, state IDLE.
//     A later mem_rvalid is ignored.

Source files
------------

// File: rtl/writeback_if.sv
// Writeback unit bus bundle.
// Carries the upstream retire handshake, the load-response channel and the
// register-file write port.
//   master : environment side. Drives the instruction fields and the memory
//            response, and observes in_ready and the write port.
//   slave  : writeback unit side.
interface writeback_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_reg_wr;
    logic [1:0]  in_wb_sel;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic [31:0] in_alu;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  Rw;
    logic        RegWr;
    logic [31:0] busW;
    logic        wb_err;

    modport master (
        output in_valid, in_rd, in_reg_wr, in_wb_sel, in_funct3, in_addr_lo,
               in_alu, in_pc, in_imm, mem_rvalid, mem_rdata,
        input  in_ready, Rw, RegWr, busW, wb_err
    );

    modport slave (
        input  in_valid, in_rd, in_reg_wr, in_wb_sel, in_funct3, in_addr_lo,
               in_alu, in_pc, in_imm, mem_rvalid, mem_rdata,
        output in_ready, Rw, RegWr, busW, wb_err
    );
endinterface

// File: rtl/writeback_unit.sv
// Final pipeline stage that produces the register-file write port.
// It accepts one retiring instruction per handshake and selects the write data
// from the ALU result, load data, PC+4 or the immediate. Loads wait in
// LOAD_WAIT for mem_rvalid, with a timeout. The unit extracts and sign- or
// zero-extends bytes and halves.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   bus        : writeback_if.slave. Carries the handshake, the load response
//                and Rw/RegWr/busW/wb_err.
//   retire_cnt : count of retired instructions (wraps)
module writeback_unit #(
    parameter int unsigned LOAD_TIMEOUT = 16,
    parameter int unsigned RETIRE_W     = 32
) (
    input  logic                clk,
    input  logic                rst,
    writeback_if.slave          bus,
    output logic [RETIRE_W-1:0] retire_cnt
);
    localparam int unsigned TW = $clog2(LOAD_TIMEOUT + 1);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t              state_q, state_d;
    logic [4:0]          rd_q, rd_d;
    logic                reg_wr_q, reg_wr_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          addr_lo_q, addr_lo_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic [TW-1:0]       tmo_inc;
    logic [4:0]          rw_q, rw_d;
    logic                regwr_q, regwr_d;
    logic [31:0]         busw_q, busw_d;
    logic                err_q, err_d;
    logic [RETIRE_W-1:0] retire_q, retire_d;

    logic                accept;
    logic                load_bad;
    logic [31:0]         direct_data;
    logic [7:0]          load_byte;
    logic [15:0]         load_half;
    logic [31:0]         load_data;

    assign bus.in_ready = (state_q == IDLE);
    assign accept       = bus.in_valid && (state_q == IDLE);
    assign tmo_inc      = tmo_q + TW'(1);

    // A load is rejected up front if funct3 is not a load width or the
    // offset is misaligned for that width.
    always_comb begin
        case (bus.in_funct3)
            3'b000, 3'b100: load_bad = 1'b0;
            3'b001, 3'b101: load_bad = bus.in_addr_lo[0];
            3'b010:         load_bad = (bus.in_addr_lo != 2'b00);
            default:        load_bad = 1'b1;
        endcase
    end

    always_comb begin
        case (bus.in_wb_sel)
            2'b10:   direct_data = bus.in_pc + 32'd4;
            2'b11:   direct_data = bus.in_imm;
            default: direct_data = bus.in_alu;
        endcase
    end

    // Little-endian lane extraction from the latched width and offset.
    always_comb begin
        case (addr_lo_q)
            2'd0:    load_byte = bus.mem_rdata[7:0];
            2'd1:    load_byte = bus.mem_rdata[15:8];
            2'd2:    load_byte = bus.mem_rdata[23:16];
            default: load_byte = bus.mem_rdata[31:24];
        endcase
        load_half = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        reg_wr_d  = reg_wr_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        tmo_d     = tmo_q;
        rw_d      = rw_q;
        busw_d    = busw_q;
        regwr_d   = 1'b0;
        err_d     = 1'b0;
        retire_d  = retire_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_wb_sel != 2'b01) begin
                        retire_d = retire_q + RETIRE_W'(1);
                        if (bus.in_reg_wr && (bus.in_rd != 5'd0)) begin
                            regwr_d = 1'b1;
                            rw_d    = bus.in_rd;
                            busw_d  = direct_data;
                        end
                    end else if (load_bad) begin
                        err_d    = 1'b1;
                        retire_d = retire_q + RETIRE_W'(1);
                    end else begin
                        rd_d      = bus.in_rd;
                        reg_wr_d  = bus.in_reg_wr;
                        funct3_d  = bus.in_funct3;
                        addr_lo_d = bus.in_addr_lo;
                        tmo_d     = '0;
                        state_d   = LOAD_WAIT;
                    end
                end
            end
            LOAD_WAIT: begin
                // Data arriving on the last allowed cycle beats the timeout.
                if (bus.mem_rvalid) begin
                    retire_d = retire_q + RETIRE_W'(1);
                    state_d  = IDLE;
                    tmo_d    = '0;
                    if (reg_wr_q && (rd_q != 5'd0)) begin
                        regwr_d = 1'b1;
                        rw_d    = rd_q;
                        busw_d  = load_data;
                    end
                end else if (tmo_inc == TW'(LOAD_TIMEOUT)) begin
                    err_d    = 1'b1;
                    retire_d = retire_q + RETIRE_W'(1);
                    state_d  = IDLE;
                    tmo_d    = '0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            reg_wr_q  <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            tmo_q     <= '0;
            rw_q      <= '0;
            regwr_q   <= 1'b0;
            busw_q    <= '0;
            err_q     <= 1'b0;
            retire_q  <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            reg_wr_q  <= reg_wr_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            tmo_q     <= tmo_d;
            rw_q      <= rw_d;
            regwr_q   <= regwr_d;
            busw_q    <= busw_d;
            err_q     <= err_d;
            retire_q  <= retire_d;
        end
    end

    assign bus.Rw     = rw_q;
    assign bus.RegWr  = regwr_q;
    assign bus.busW   = busw_q;
    assign bus.wb_err = err_q;
    assign retire_cnt = retire_q;
endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit. It runs directed scenarios with
// literal expectations first, then randomized traffic. A behavioural model
// tracks the outstanding load and the expected write port, and a negedge
// process compares every output on every cycle.
module tb_writeback_unit;
    localparam int unsigned LT = 16;
    localparam int unsigned RW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [RW-1:0] retire_cnt;

    writeback_if bus();

    writeback_unit #(.LOAD_TIMEOUT(LT), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: whether a load is outstanding, and what it needs.
    bit            m_busy;
    int            m_wait;
    logic [4:0]    m_rd;
    bit            m_reg_wr;
    logic [2:0]    m_f3;
    logic [1:0]    m_off;
    logic [4:0]    exp_rw;
    bit            exp_regwr;
    logic [31:0]   exp_busw;
    bit            exp_err;
    logic [RW-1:0] exp_retire;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit load_legal(input logic [2:0] f3, input logic [1:0] off);
        int unsigned size;
        if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        size = 1 << f3[1:0];
        return (int'(off) % size) == 0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] word);
        int unsigned    size;
        int unsigned    shift;
        longint unsigned w;
        longint unsigned v;
        size = 1 << f3[1:0];
        if (size == 4) return word;
        w     = word;
        shift = (size == 1) ? int'(off) * 8 : (int'(off) / 2) * 16;
        v     = (w >> shift) % (64'd1 << (8 * size));
        if (f3 < 3'd4 && v >= (64'd1 << (8 * size - 1)))
            v = v + (64'd1 << 32) - (64'd1 << (8 * size));
        return v[31:0];
    endfunction

    task automatic model_edge();
        exp_regwr = 1'b0;
        exp_err   = 1'b0;
        if (!rst) begin
            m_busy = 1'b0; m_wait = 0;
            exp_rw = '0; exp_busw = '0; exp_retire = '0;
        end else if (!m_busy) begin
            if (bus.in_valid) begin
                if (bus.in_wb_sel != 2'b01) begin
                    exp_retire++;
                    if (bus.in_reg_wr && bus.in_rd != 5'd0) begin
                        exp_regwr = 1'b1;
                        exp_rw    = bus.in_rd;
                        if (bus.in_wb_sel == 2'b00)      exp_busw = bus.in_alu;
                        else if (bus.in_wb_sel == 2'b10) exp_busw = bus.in_pc + 32'd4;
                        else                             exp_busw = bus.in_imm;
                    end
                end else if (!load_legal(bus.in_funct3, bus.in_addr_lo)) begin
                    exp_err = 1'b1;
                    exp_retire++;
                end else begin
                    m_busy = 1'b1; m_wait = 0;
                    m_rd = bus.in_rd; m_reg_wr = bus.in_reg_wr;
                    m_f3 = bus.in_funct3; m_off = bus.in_addr_lo;
                end
            end
        end else if (bus.mem_rvalid) begin
            m_busy = 1'b0;
            exp_retire++;
            if (m_reg_wr && m_rd != 5'd0) begin
                exp_regwr = 1'b1;
                exp_rw    = m_rd;
                exp_busw  = load_value(m_f3, m_off, bus.mem_rdata);
            end
        end else begin
            m_wait++;
            if (m_wait == LT) begin
                m_busy  = 1'b0;
                exp_err = 1'b1;
                exp_retire++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready",   {31'd0, bus.in_ready}, {31'd0, !m_busy});
            check("RegWr",      {31'd0, bus.RegWr},    {31'd0, exp_regwr});
            check("wb_err",     {31'd0, bus.wb_err},   {31'd0, exp_err});
            check("Rw",         {27'd0, bus.Rw},       {27'd0, exp_rw});
            check("busW",       bus.busW,              exp_busw);
            check("retire_cnt", retire_cnt,            exp_retire);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic reg_wr,
                         input logic [2:0] f3, input logic [1:0] off, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] imm);
        bus.in_valid = 1'b1; bus.in_wb_sel = sel; bus.in_rd = rd; bus.in_reg_wr = reg_wr;
        bus.in_funct3 = f3; bus.in_addr_lo = off; bus.in_alu = alu; bus.in_pc = pc;
        bus.in_imm = imm;
    endtask

    // Accept a load, then return data on the gap-th cycle after the accept.
    task automatic run_load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                            input int gap, input logic [31:0] data);
        issue(2'b01, rd, 1'b1, f3, off, '0, '0, '0);
        tick();
        bus.in_valid = 1'b0;
        repeat (gap - 1) tick();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = data;
        tick();
        bus.mem_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_reg_wr = 1'b0; bus.in_wb_sel = '0;
        bus.in_funct3 = '0; bus.in_addr_lo = '0; bus.in_alu = '0; bus.in_pc = '0;
        bus.in_imm = '0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        tick();
        chk_en = 1'b1;
        check("reset_RegWr", {31'd0, bus.RegWr}, 32'd0);
        check("reset_retire", retire_cnt, 32'd0);
        check("reset_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b1;

        // ALU write
        issue(2'b00, 5'd5, 1'b1, 3'd0, 2'd0, 32'hDEADBEEF, '0, '0);
        tick();
        bus.in_valid = 1'b0;
        check("alu_RegWr", {31'd0, bus.RegWr}, 32'd1);
        check("alu_Rw", {27'd0, bus.Rw}, 32'd5);
        check("alu_busW", bus.busW, 32'hDEADBEEF);
        check("alu_retire", retire_cnt, 32'd1);

        // LB / LBU from byte 3, data three cycles after accept
        run_load(3'b000, 2'd3, 5'd7, 3, 32'h80FF_0000);
        check("lb_RegWr", {31'd0, bus.RegWr}, 32'd1);
        check("lb_busW", bus.busW, 32'hFFFFFF80);
        tick();
        check("lb_pulse_once", {31'd0, bus.RegWr}, 32'd0);
        run_load(3'b100, 2'd3, 5'd7, 3, 32'h80FF_0000);
        check("lbu_busW", bus.busW, 32'h00000080);
        check("lbu_retire", retire_cnt, 32'd3);

        // LW timeout, then data on the last allowed cycle
        issue(2'b01, 5'd9, 1'b1, 3'b010, 2'd0, '0, '0, '0);
        tick();
        bus.in_valid = 1'b0;
        repeat (LT - 1) tick();
        check("tmo_no_err_early", {31'd0, bus.wb_err}, 32'd0);
        tick();
        check("tmo_err", {31'd0, bus.wb_err}, 32'd1);
        check("tmo_no_write", {31'd0, bus.RegWr}, 32'd0);
        check("tmo_ready", {31'd0, bus.in_ready}, 32'd1);
        check("tmo_retire", retire_cnt, 32'd4);
        run_load(3'b010, 2'd0, 5'd9, LT, 32'h1234_5678);
        check("lastcyc_RegWr", {31'd0, bus.RegWr}, 32'd1);
        check("lastcyc_no_err", {31'd0, bus.wb_err}, 32'd0);
        check("lastcyc_busW", bus.busW, 32'h1234_5678);
        check("lastcyc_retire", retire_cnt, 32'd5);

        // PC+4 wrap; IMM to x0
        issue(2'b10, 5'd1, 1'b1, 3'd0, 2'd0, '0, 32'hFFFFFFFC, '0);
        tick();
        check("pc4_busW", bus.busW, 32'h0);
        check("pc4_RegWr", {31'd0, bus.RegWr}, 32'd1);
        issue(2'b11, 5'd0, 1'b1, 3'd0, 2'd0, '0, '0, 32'h12345000);
        tick();
        bus.in_valid = 1'b0;
        check("imm_x0_RegWr", {31'd0, bus.RegWr}, 32'd0);
        check("imm_x0_retire", retire_cnt, 32'd7);

        // Misaligned LH, then four back-to-back ALU ops
        issue(2'b01, 5'd3, 1'b1, 3'b001, 2'd1, '0, '0, '0);
        tick();
        check("lh_mis_err", {31'd0, bus.wb_err}, 32'd1);
        check("lh_mis_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, 5'(10 + i), 1'b1, 3'd0, 2'd0, 32'(i * 3 + 1), '0, '0);
            tick();
            check("b2b_RegWr", {31'd0, bus.RegWr}, 32'd1);
            check("b2b_Rw", {27'd0, bus.Rw}, 32'(10 + i));
        end
        bus.in_valid = 1'b0;
        check("b2b_retire", retire_cnt, 32'd12);

        // Reset during LOAD_WAIT; late rvalid ignored
        issue(2'b01, 5'd4, 1'b1, 3'b010, 2'd0, '0, '0, '0);
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_wait_busW", bus.busW, 32'd0);
        check("rst_wait_Rw", {27'd0, bus.Rw}, 32'd0);
        check("rst_wait_retire", retire_cnt, 32'd0);
        check("rst_wait_ready", {31'd0, bus.in_ready}, 32'd1);
        rst = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
        tick();
        bus.mem_rvalid = 1'b0;
        check("late_rvalid_RegWr", {31'd0, bus.RegWr}, 32'd0);
        check("late_rvalid_retire", retire_cnt, 32'd0);

        // Randomized traffic: frequent responses first, then sparse ones that provoke timeouts
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 1500; c++) begin
                logic [2:0] f3v;
                rst = ($urandom_range(0, 299) != 0);
                bus.in_valid   = $urandom_range(0, 1) == 1;
                bus.in_wb_sel  = 2'($urandom_range(0, 3));
                bus.in_rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                bus.in_reg_wr  = $urandom_range(0, 4) != 0;
                f3v = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 4))
                        0: f3v = 3'd0; 1: f3v = 3'd1; 2: f3v = 3'd2; 3: f3v = 3'd4;
                        default: f3v = 3'd5;
                    endcase
                end
                bus.in_funct3  = f3v;
                bus.in_addr_lo = 2'($urandom_range(0, 3));
                bus.in_alu     = $urandom;
                bus.in_pc      = ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom;
                bus.in_imm     = $urandom;
                bus.mem_rvalid = (phase == 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 19) == 0);
                bus.mem_rdata  = $urandom;
                tick();
            end
        end
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_rvalid = 1'b0;
        repeat (LT + 2) tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
